// File: rtl/dds_sweep_ctrl_if.sv
// Sweep-controller bus: configuration and control from the host (master),
// phase increment and status back from the controller (slave).
//   start_i/stop_i/mode_i            sweep control
//   inc_start_i/inc_stop_i/inc_step_i sweep endpoints and step magnitude
//   dwell_i                          hold time per value, minus one
//   phase_inc_o                      phase increment toward the DDS
//   busy_o/done_o/wrap_o             sweep status and 1-cycle event pulses
interface dds_sweep_ctrl_if #(
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned DWELL_WIDTH = 16
);
  logic                   start_i;
  logic                   stop_i;
  logic                   mode_i;
  logic [PHASE_WIDTH-1:0] inc_start_i;
  logic [PHASE_WIDTH-1:0] inc_stop_i;
  logic [PHASE_WIDTH-1:0] inc_step_i;
  logic [DWELL_WIDTH-1:0] dwell_i;
  logic [PHASE_WIDTH-1:0] phase_inc_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   wrap_o;

  modport master (
    output start_i, stop_i, mode_i, inc_start_i, inc_stop_i, inc_step_i, dwell_i,
    input  phase_inc_o, busy_o, done_o, wrap_o
  );

  modport slave (
    input  start_i, stop_i, mode_i, inc_start_i, inc_stop_i, inc_step_i, dwell_i,
    output phase_inc_o, busy_o, done_o, wrap_o
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller feeding a DDS phase_inc_i input. Steps the phase
// increment from a start to a stop value, holding each value dwell+1 cycles,
// in single-shot or continuous mode, up or down, clamping at the stop value.
// Ports:
//   clk_i    clock
//   arstn_i  asynchronous active-low reset
//   sw       dds_sweep_ctrl_if.slave (config/control in, phase_inc/status out)
// Build option: define SWEEP_TRIANGLE_EN to make continuous sweeps reverse at
// each endpoint (triangle) instead of jumping back to the start (sawtooth).
module dds_sweep_ctrl #(
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  dds_sweep_ctrl_if.slave sw
);

  localparam int unsigned PW = PHASE_WIDTH;
  localparam int unsigned DW = DWELL_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Latched sweep configuration; origin/target swap on each triangle reversal.
  typedef struct packed {
    logic          mode;
    logic          dir_down;
    logic [PW-1:0] origin;
    logic [PW-1:0] target;
    logic [PW-1:0] step;
    logic [DW-1:0] dwell;
  } cfg_t;

  state_t        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;

  logic [PW-1:0] step_eff;
  logic [PW:0]   sum_up;
  logic [PW:0]   diff_dn;
  logic [PW-1:0] next_val;

  // Next value toward the target, clamped on overshoot, carry or borrow.
  always_comb begin
    step_eff = (cfg_q.step == '0) ? PW'(1) : cfg_q.step;
    sum_up   = {1'b0, phase_q} + {1'b0, step_eff};
    diff_dn  = {1'b0, phase_q} - {1'b0, step_eff};
    if (cfg_q.dir_down) begin
      next_val = (diff_dn[PW] || (diff_dn[PW-1:0] <= cfg_q.target)) ? cfg_q.target
                                                                     : diff_dn[PW-1:0];
    end else begin
      next_val = (sum_up[PW] || (sum_up[PW-1:0] >= cfg_q.target)) ? cfg_q.target
                                                                  : sum_up[PW-1:0];
    end
  end

  // Next-state and output logic; stop_i outranks start and end of sweep.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (sw.stop_i) begin
          phase_d = '0;
          busy_d  = 1'b0;
        end else if (sw.start_i) begin
          cfg_d.mode     = sw.mode_i;
          cfg_d.dir_down = (sw.inc_stop_i < sw.inc_start_i);
          cfg_d.origin   = sw.inc_start_i;
          cfg_d.target   = sw.inc_stop_i;
          cfg_d.step     = sw.inc_step_i;
          cfg_d.dwell    = sw.dwell_i;
          phase_d        = sw.inc_start_i;
          busy_d         = 1'b1;
          cnt_d          = '0;
          state_d        = HOLD;
        end
      end

      HOLD: begin
        if (sw.stop_i) begin
          state_d = IDLE;
          phase_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != cfg_q.dwell) begin
          cnt_d = cnt_q + DW'(1);
        end else begin
          cnt_d = '0;
          if (phase_q == cfg_q.target) begin
            if (!cfg_q.mode) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              wrap_d = 1'b1;
`ifdef SWEEP_TRIANGLE_EN
              // Only reachable with start==stop: the single value repeats.
              phase_d = phase_q;
`else
              phase_d = cfg_q.origin;
`endif
            end
          end else begin
            phase_d = next_val;
`ifdef SWEEP_TRIANGLE_EN
            // Reverse on arrival so the endpoint is emitted only once.
            if (cfg_q.mode && (next_val == cfg_q.target)) begin
              wrap_d         = 1'b1;
              cfg_d.origin   = cfg_q.target;
              cfg_d.target   = cfg_q.origin;
              cfg_d.dir_down = ~cfg_q.dir_down;
            end
`endif
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sw.phase_inc_o = phase_q;
  assign sw.busy_o      = busy_q;
  assign sw.done_o      = done_q;
  assign sw.wrap_o      = wrap_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: directed sweeps plus randomized traffic,
// checked by a scoreboard against a value-list reference model.
module tb_dds_sweep_ctrl;

  localparam int unsigned PW = 16;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [PW-1:0] phase;
    logic          busy;
    logic          done;
    logic          wrap;
  } obs_t;

  logic clk_i   = 1'b0;
  logic arstn_i = 1'b0;

  dds_sweep_ctrl_if #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) sw ();

  dds_sweep_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .sw      (sw)
  );

  always #5 clk_i = ~clk_i;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t exp_q[$];

  // Reference model: the full cyclic list of values a sweep emits.
  int   cyc_q[$];
  int   m_nf     = 0;
  bit   m_active = 1'b0;
  bit   m_mode   = 1'b0;
  bit   m_tri    = 1'b0;
  int   m_dwell  = 0;
  int   m_hold   = 0;
  int   m_pos    = 0;
  obs_t m_out    = '0;

  function automatic int next_toward(input int cur, input int tgt, input int s);
    int st;
    int n;
    st = (s == 0) ? 1 : s;
    if (tgt >= cur) begin
      n = cur + st;
      return (n >= tgt) ? tgt : n;
    end
    n = cur - st;
    return (n <= tgt) ? tgt : n;
  endfunction

  function automatic void build(input int a, input int b, input int s);
    int v;
    cyc_q.delete();
    v = a;
    cyc_q.push_back(v);
    while (v != b) begin
      v = next_toward(v, b, s);
      cyc_q.push_back(v);
    end
    m_nf = cyc_q.size();
    if (m_tri && m_nf > 1) begin
      v = b;
      while (v != a) begin
        v = next_toward(v, a, s);
        if (v != a) cyc_q.push_back(v);
      end
    end
  endfunction

  function automatic void model_step(input bit st, input bit sp, input bit md,
                                     input int a, input int b, input int s, input int dw);
    int idx;
    m_out.done = 1'b0;
    m_out.wrap = 1'b0;
    if (sp) begin
      m_active    = 1'b0;
      m_out.busy  = 1'b0;
      m_out.phase = '0;
    end else if (!m_active) begin
      if (st) begin
        m_mode = md;
`ifdef SWEEP_TRIANGLE_EN
        m_tri = md;
`else
        m_tri = 1'b0;
`endif
        build(a, b, s);
        m_dwell     = dw;
        m_active    = 1'b1;
        m_hold      = 0;
        m_pos       = 0;
        m_out.phase = PW'(cyc_q[0]);
        m_out.busy  = 1'b1;
      end
    end else if (m_hold < m_dwell) begin
      m_hold++;
    end else begin
      m_hold = 0;
      m_pos++;
      if (!m_mode && m_pos == m_nf) begin
        m_active   = 1'b0;
        m_out.busy = 1'b0;
        m_out.done = 1'b1;
      end else begin
        idx         = m_pos % cyc_q.size();
        m_out.phase = PW'(cyc_q[idx]);
        m_out.wrap  = (idx == 0) || (m_tri && idx == m_nf - 1);
      end
    end
  endfunction

  function automatic obs_t obs_now();
    return {sw.phase_inc_o, sw.busy_o, sw.done_o, sw.wrap_o};
  endfunction

  function automatic void check(input string name, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got phase=%h busy=%b done=%b wrap=%b want phase=%h busy=%b done=%b wrap=%b",
               name, $time, got.phase, got.busy, got.done, got.wrap,
               exp.phase, exp.busy, exp.done, exp.wrap);
    end
  endfunction

  // Monitor: one expected entry per clock edge, popped just after the edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", obs_now(), e);
      end
    end
  end

  task automatic drive_and_push(input bit st, input bit sp, input bit md,
                                input int a, input int b, input int s, input int dw);
    sw.start_i     = st;
    sw.stop_i      = sp;
    sw.mode_i      = md;
    sw.inc_start_i = PW'(a);
    sw.inc_stop_i  = PW'(b);
    sw.inc_step_i  = PW'(s);
    sw.dwell_i     = DW'(dw);
    model_step(st, sp, md, a, b, s, dw);
    exp_q.push_back(m_out);
  endtask

  task automatic cyc(input bit st, input bit sp, input bit md,
                     input int a, input int b, input int s, input int dw);
    @(negedge clk_i);
    drive_and_push(st, sp, md, a, b, s, dw);
  endtask

  task automatic sweep(input bit md, input int a, input int b, input int s,
                       input int dw, input int n);
    cyc(1'b1, 1'b0, md, a, b, s, dw);
    repeat (n) cyc(1'b0, 1'b0, md, a, b, s, dw);
  endtask

  task automatic rnd_cfg(output bit md, output int a, output int b,
                         output int s, output int dw);
    int rng;
    md = 1'($urandom_range(0, 1));
    a  = $urandom_range(0, 65535);
    case ($urandom_range(0, 3))
      0:       b = (a + $urandom_range(0, 40)) % 65536;
      1:       begin a = $urandom_range(16'hFF00, 16'hFFFF); b = 16'hFFFF; end
      default: b = $urandom_range(0, 65535);
    endcase
    rng = (b > a) ? (b - a) : (a - b);
    s   = rng / $urandom_range(1, 10);
    if ($urandom_range(0, 7) == 0) s = rng + $urandom_range(0, 1000);
    if (s > 65535) s = 65535;
    dw = $urandom_range(0, 3);
  endtask

  initial begin
    bit md;
    int a, b, s, dw, len;
    sw.start_i = 1'b0; sw.stop_i = 1'b0; sw.mode_i = 1'b0;
    sw.inc_start_i = '0; sw.inc_stop_i = '0; sw.inc_step_i = '0; sw.dwell_i = '0;

    #3;
    check("reset_state", obs_now(), obs_t'(0));
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;

    // Single-shot up, dwell 2.
    sweep(1'b0, 100, 400, 100, 2, 15);
    // Clamp, down, carry clamp, zero step, start==stop.
    sweep(1'b0, 0, 250, 100, 0, 6);
    sweep(1'b0, 400, 100, 150, 0, 5);
    sweep(1'b0, 16'hFF00, 16'hFFFF, 16'h80, 0, 5);
    sweep(1'b0, 5, 8, 0, 0, 6);
    sweep(1'b0, 7, 7, 3, 1, 4);
    // Continuous sweeps, then abort.
    sweep(1'b1, 10, 30, 10, 0, 12);
    cyc(1'b0, 1'b1, 1'b1, 10, 30, 10, 0);
    sweep(1'b1, 500, 100, 200, 1, 14);
    cyc(1'b0, 1'b1, 1'b1, 500, 100, 200, 1);
    // Abort during value 200, then start+stop together in IDLE.
    sweep(1'b0, 100, 400, 100, 2, 3);
    cyc(1'b0, 1'b1, 1'b0, 100, 400, 100, 2);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 100, 400, 100, 2);
    cyc(1'b1, 1'b1, 1'b0, 100, 400, 100, 2);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 100, 400, 100, 2);
    // Start with different config while busy is ignored.
    sweep(1'b0, 100, 400, 100, 1, 2);
    cyc(1'b1, 1'b0, 1'b1, 7, 9, 1, 0);
    repeat (8) cyc(1'b0, 1'b0, 1'b1, 7, 9, 1, 0);

    // Asynchronous reset mid-sweep.
    sweep(1'b0, 100, 400, 100, 2, 5);
    @(negedge clk_i);
    #2 arstn_i = 1'b0;
    #1 check("reset_async", obs_now(), obs_t'(0));
    m_active = 1'b0;
    m_out    = '0;
    exp_q.push_back(m_out);
    @(negedge clk_i);
    arstn_i = 1'b1;
    drive_and_push(1'b0, 1'b0, 1'b0, 100, 400, 100, 2);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 100, 400, 100, 2);

    // Randomized traffic with garbage config and stray start/stop.
    for (int t = 0; t < 250; t++) begin
      rnd_cfg(md, a, b, s, dw);
      cyc(1'b1, 1'b0, md, a, b, s, dw);
      len = $urandom_range(1, 60);
      for (int c = 0; c < len; c++) begin
        rnd_cfg(md, a, b, s, dw);
        cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0), md, a, b, s, dw);
      end
      if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b1, md, a, b, s, dw);
    end

    repeat (2) cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    @(posedge clk_i);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
